// File: rtl/alu_request_scheduler_pkg.sv
// Shared definitions for the ALU request scheduler.
//   - opcode encodings understood by alu_core
//   - scheduler FSM state encoding
//   - fixed result constants produced by the test opcodes
package alu_request_scheduler_pkg;

  localparam logic [2:0] OP_ADD_RC      = 3'b000;  // ripple-carry add
  localparam logic [2:0] OP_ADD_BH      = 3'b001;  // behavioural add
  localparam logic [2:0] OP_NAND_XNOR   = 3'b010;  // {~(a&b), ~(a^b)}
  localparam logic [2:0] OP_ONEHOT_PAIR = 3'b011;  // a one-hot and b has two bits set
  localparam logic [2:0] OP_NONZERO     = 3'b100;  // any operand bit set
  localparam logic [2:0] OP_CAT_NB      = 3'b110;  // {a, ~b}

  localparam logic [7:0] RES_MATCH   = 8'hF0;
  localparam logic [7:0] RES_NONZERO = 8'h0F;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU function core shared by all requesters.
// Ports:
//   i_op  [2:0]        opcode (see package encodings)
//   i_a   [DATA_W-1:0] operand A
//   i_b   [DATA_W-1:0] operand B
//   o_res [RES_W-1:0]  result, zero-extended; unused opcodes give 0
module alu_core
  import alu_request_scheduler_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter int RES_W  = 8
) (
  input  logic [2:0]        i_op,
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  output logic [RES_W-1:0]  o_res
);

  logic [DATA_W:0]   w_carry;
  logic [DATA_W-1:0] w_sum_bits;
  logic [DATA_W:0]   w_sum_rc;
  logic [DATA_W:0]   w_sum_bh;
  logic              w_match;

  // Bit-level full-adder chain; its result must agree with the '+' path.
  assign w_carry[0] = 1'b0;
  for (genvar g = 0; g < DATA_W; g++) begin : g_full_adder
    assign w_sum_bits[g] = i_a[g] ^ i_b[g] ^ w_carry[g];
    assign w_carry[g+1]  = (i_a[g] & i_b[g]) | (w_carry[g] & (i_a[g] ^ i_b[g]));
  end
  assign w_sum_rc = {w_carry[DATA_W], w_sum_bits};
  assign w_sum_bh = {1'b0, i_a} + {1'b0, i_b};

  // For 4-bit b the set {3,5,6,9,A,C} is exactly the values with two bits set.
  assign w_match = $onehot(i_a) && ($countones(i_b) == 2);

  always_comb begin
    o_res = '0;
    case (i_op)
      OP_ADD_RC:      o_res = RES_W'(w_sum_rc);
      OP_ADD_BH:      o_res = RES_W'(w_sum_bh);
      OP_NAND_XNOR:   o_res = RES_W'({~(i_a & i_b), ~(i_a ^ i_b)});
      OP_ONEHOT_PAIR: o_res = w_match ? RES_W'(RES_MATCH) : '0;
      OP_NONZERO:     o_res = ((|i_a) || (|i_b)) ? RES_W'(RES_NONZERO) : '0;
      OP_CAT_NB:      o_res = RES_W'({i_a, ~i_b});
      default:        o_res = '0;
    endcase
  end

endmodule

// File: rtl/alu_request_scheduler.sv
// Shares one ALU between NREQ requesters with round-robin arbitration.
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high; valid may rise or fall freely before that edge, and the data
// it qualifies is only sampled at the transfer edge.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   req_valid/req_ready [NREQ] request handshake per requester
//   req_op [3*NREQ]            opcodes, slice [3i+2:3i]
//   req_a/req_b [DATA_W*NREQ]  operands, slice per requester
//   resp_valid/resp_ready      response handshake, resp_valid one-hot or zero
//   resp_data [RES_W]          result of the granted transaction
//   busy                       high whenever the FSM is not idle
//   op_count [8]               completed responses, wraps
//   dbg_state [2]              current FSM state
module alu_request_scheduler
  import alu_request_scheduler_pkg::*;
#(
  parameter int NREQ   = 2,
  parameter int DATA_W = 4,
  parameter int RES_W  = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [3*NREQ-1:0]      req_op,
  input  logic [DATA_W*NREQ-1:0] req_a,
  input  logic [DATA_W*NREQ-1:0] req_b,
  output logic [NREQ-1:0]        resp_valid,
  input  logic [NREQ-1:0]        resp_ready,
  output logic [RES_W-1:0]       resp_data,
  output logic                   busy,
  output logic [7:0]             op_count,
  output logic [1:0]             dbg_state
);

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_t            r_state;
  logic [PTR_W-1:0]  r_rr_ptr;
  logic [PTR_W-1:0]  r_gnt;
  logic [2:0]        r_op;
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_b;
  logic [NREQ-1:0]   r_resp_valid;
  logic [RES_W-1:0]  r_resp_data;
  logic [7:0]        r_op_count;

  logic              w_found;
  int                w_win_idx;
  logic [NREQ-1:0]   w_req_ready;
  logic [RES_W-1:0]  w_alu_res;

  // First valid requester scanning upward from rr_ptr, wrapping around.
  always_comb begin
    w_found   = 1'b0;
    w_win_idx = 0;
    for (int k = 0; k < NREQ; k++) begin
      if (!w_found && req_valid[(int'(r_rr_ptr) + k) % NREQ]) begin
        w_found   = 1'b1;
        w_win_idx = (int'(r_rr_ptr) + k) % NREQ;
      end
    end
  end

  // Ready is withheld during reset so a request cannot look accepted in a
  // cycle where reset discards it.
  always_comb begin
    w_req_ready = '0;
    if (!reset && (r_state == ST_IDLE) && w_found) begin
      w_req_ready[w_win_idx] = 1'b1;
    end
  end

  alu_core #(
    .DATA_W (DATA_W),
    .RES_W  (RES_W)
  ) u_alu_core (
    .i_op  (r_op),
    .i_a   (r_a),
    .i_b   (r_b),
    .o_res (w_alu_res)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_rr_ptr     <= '0;
      r_gnt        <= '0;
      r_op         <= '0;
      r_a          <= '0;
      r_b          <= '0;
      r_resp_valid <= '0;
      r_resp_data  <= '0;
      r_op_count   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_found) begin
            r_op     <= req_op[3*w_win_idx +: 3];
            r_a      <= req_a[DATA_W*w_win_idx +: DATA_W];
            r_b      <= req_b[DATA_W*w_win_idx +: DATA_W];
            r_gnt    <= PTR_W'(w_win_idx);
            r_rr_ptr <= PTR_W'((w_win_idx + 1) % NREQ);
            r_state  <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          r_resp_data         <= w_alu_res;
          r_resp_valid        <= '0;
          r_resp_valid[r_gnt] <= 1'b1;
          r_state             <= ST_RESP;
        end
        ST_RESP: begin
          // Only the granted requester's ready can complete the response.
          if (resp_ready[r_gnt]) begin
            r_resp_valid <= '0;
            r_op_count   <= r_op_count + 8'd1;
            r_state      <= ST_IDLE;
          end
        end
        default: begin
          r_resp_valid <= '0;
          r_state      <= ST_IDLE;
        end
      endcase
    end
  end

  assign req_ready  = w_req_ready;
  assign resp_valid = r_resp_valid;
  assign resp_data  = r_resp_data;
  assign busy       = (r_state != ST_IDLE);
  assign op_count   = r_op_count;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_alu_request_scheduler.sv
module tb_alu_request_scheduler;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] req_valid;
  logic [1:0] req_ready;
  logic [5:0] req_op;
  logic [7:0] req_a;
  logic [7:0] req_b;
  logic [1:0] resp_valid;
  logic [1:0] resp_ready;
  logic [7:0] resp_data;
  logic       busy;
  logic [7:0] op_count;
  logic [1:0] dbg_state;

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] exp_count;
  int         exp_ptr;
  logic [7:0] exp_q[$];

  alu_request_scheduler dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .busy       (busy),
    .op_count   (op_count),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL timeout checks=%0d", n_checks);
    $fatal(1, "simulation time limit");
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- drivers ----------------
  // One transaction from requester r as the only active requester. Waits
  // `stall` RESP cycles with resp_ready low (other requester's ready high).
  task automatic do_txn(input int r, input logic [2:0] op, input logic [3:0] a,
                        input logic [3:0] b, input logic [7:0] exp, input int stall);
    logic [1:0] oh;
    oh = 2'b01 << r;
    @(negedge clk);
    req_valid[r]   = 1'b1;
    req_op[3*r+:3] = op;
    req_a[4*r+:4]  = a;
    req_b[4*r+:4]  = b;
    exp_q.push_back(exp);
    #1;
    check("idle_req_ready", req_ready, oh);
    @(posedge clk); #1;
    // Handshake done: operand changes must not matter any more.
    req_valid[r]  = 1'b0;
    req_a[4*r+:4] = ~a;
    req_b[4*r+:4] = ~b;
    check("exec_busy", busy, 1);
    check("exec_resp_valid", resp_valid, 0);
    check("exec_req_ready", req_ready, 0);
    @(posedge clk); #1;
    for (int s = 0; s < stall; s++) begin
      resp_ready[r ^ 1] = 1'b1;
      req_valid[r ^ 1]  = 1'b1;
      #1;
      check("stall_resp_valid", resp_valid, oh);
      check("stall_resp_data", resp_data, exp_q[0]);
      check("stall_busy", busy, 1);
      check("stall_req_ready", req_ready, 0);
      @(posedge clk); #1;
      resp_ready = 2'b00;
      req_valid  = 2'b00;
    end
    check("resp_valid", resp_valid, oh);
    check("resp_data", resp_data, exp_q.pop_front());
    resp_ready[r] = 1'b1;
    @(posedge clk); #1;
    resp_ready = 2'b00;
    exp_count  = exp_count + 8'd1;
    exp_ptr    = r ^ 1;
    check("done_resp_valid", resp_valid, 0);
    check("done_busy", busy, 0);
    check("done_op_count", op_count, exp_count);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset      = 1'b1;
    req_valid  = 2'b11;
    req_op     = 6'b000_000;
    req_a      = 8'h77;
    req_b      = 8'h99;
    resp_ready = 2'b00;
    exp_count  = 8'd0;
    exp_ptr    = 0;

    // Reset held two cycles with both requesters valid.
    repeat (2) begin
      @(negedge clk);
      check("rst_req_ready", req_ready, 0);
    end
    check("rst_resp_valid", resp_valid, 0);
    check("rst_resp_data", resp_data, 0);
    check("rst_busy", busy, 0);
    check("rst_op_count", op_count, 0);
    check("rst_state", dbg_state, 0);
    req_valid = 2'b00;
    reset     = 1'b0;
    @(posedge clk); #1;
    check("post_rst_busy", busy, 0);

    // Adds: ripple-carry and behavioural paths.
    do_txn(0, 3'b000, 4'h7, 4'h9, 8'h10, 0);
    do_txn(0, 3'b001, 4'h7, 4'h9, 8'h10, 0);
    do_txn(1, 3'b000, 4'hF, 4'hF, 8'h1E, 0);
    do_txn(0, 3'b001, 4'hF, 4'h1, 8'h10, 0);

    // Both requesters valid continuously: grants alternate from rr_ptr.
    req_valid  = 2'b11;
    req_op     = {3'b010, 3'b010};
    req_a      = 8'hCC;
    req_b      = 8'hAA;
    resp_ready = 2'b11;
    for (int n = 0; n < 4; n++) begin
      int waited;
      waited = 0;
      while (resp_valid == 2'b00 && waited < 10) begin
        @(posedge clk); #1;
        waited++;
      end
      check("alt_grant", resp_valid, 2'b01 << exp_ptr);
      check("alt_data", resp_data, 8'h79);
      exp_ptr   = exp_ptr ^ 1;
      exp_count = exp_count + 8'd1;
      if (n == 3) req_valid = 2'b00;
      @(posedge clk); #1;
    end
    resp_ready = 2'b00;
    check("alt_op_count", op_count, exp_count);
    check("alt_idle", busy, 0);

    // Remaining opcodes.
    do_txn(0, 3'b011, 4'h4, 4'h6, 8'hF0, 0);
    do_txn(1, 3'b011, 4'h3, 4'h6, 8'h00, 0);
    do_txn(0, 3'b011, 4'h8, 4'hC, 8'hF0, 0);
    do_txn(1, 3'b011, 4'h8, 4'h7, 8'h00, 0);
    do_txn(0, 3'b100, 4'h0, 4'h0, 8'h00, 0);
    do_txn(1, 3'b100, 4'h0, 4'h1, 8'h0F, 0);
    do_txn(0, 3'b110, 4'h5, 4'h3, 8'h5C, 0);
    do_txn(1, 3'b111, 4'hF, 4'hF, 8'h00, 0);
    do_txn(0, 3'b101, 4'h9, 4'h2, 8'h00, 0);
    do_txn(1, 3'b010, 4'h0, 4'hF, 8'hF0, 0);

    // Response back-pressure for 5 cycles.
    do_txn(1, 3'b110, 4'hA, 4'h0, 8'hAF, 5);

    // Reset during EXEC drops the transaction.
    @(negedge clk);
    req_valid[1] = 1'b1;
    req_op[5:3]  = 3'b000;
    req_a[7:4]   = 4'h3;
    req_b[7:4]   = 4'h4;
    @(posedge clk); #1;
    check("pre_rst_exec", dbg_state, 1);
    req_valid = 2'b00;
    reset     = 1'b1;
    @(posedge clk); #1;
    reset     = 1'b0;
    exp_count = 8'd0;
    exp_ptr   = 0;
    repeat (3) begin
      @(posedge clk); #1;
      check("rst_exec_resp_valid", resp_valid, 0);
      check("rst_exec_busy", busy, 0);
    end
    check("rst_exec_op_count", op_count, 0);

    // 256 completed ops: counter wraps to zero.
    for (int i = 0; i < 256; i++) begin
      if (i % 2 == 0) do_txn(0, 3'b000, 4'hF, 4'hF, 8'h1E, 0);
      else            do_txn(0, 3'b100, 4'h0, 4'h0, 8'h00, 0);
      if (i == 254) check("count_255", op_count, 8'd255);
    end
    check("count_wrap", op_count, 8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
